// File: rtl/cla_multicycle_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cla_multicycle_add_ctrl: OPW-bit add/sub over NSLICE cycles on one       |
// | SLICEW-bit CLA slice. Optional macro: CLA_ADD_OVF_FLAG_EN (ovf output).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module cla_multicycle_add_ctrl_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g    = a & b;
  assign w_p    = a ^ b;
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
  assign s      = w_p ^ w_c[3:0];
  assign co     = w_c[4];
endmodule

module cla_multicycle_add_ctrl #(
  parameter int OPW    = 64,
  parameter int SLICEW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_valid,
  output logic           start_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  input  logic           sub,
  input  logic           cin,
  input  logic           abort,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [OPW-1:0] sum,
  output logic           cout,
`ifdef CLA_ADD_OVF_FLAG_EN
  output logic           ovf,
`endif
  output logic           busy
);
  localparam int NSLICE = OPW / SLICEW;
  localparam int NCLA   = SLICEW / 4;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((OPW % SLICEW) != 0 || (SLICEW % 4) != 0 || SLICEW < 4 || NSLICE < 2) begin : g_param_err
      $error("cla_multicycle_add_ctrl: illegal OPW/SLICEW combination");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [OPW-1:0]    r_a;
  logic [OPW-1:0]    r_b;
  logic [OPW-1:0]    r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [IDXW-1:0]   r_idx;

  logic [SLICEW-1:0] w_sa;
  logic [SLICEW-1:0] w_sb;
  logic [SLICEW-1:0] w_ss;
  logic [NCLA:0]     w_chain;

  assign w_sa       = r_a[r_idx*SLICEW +: SLICEW];
  assign w_sb       = r_b[r_idx*SLICEW +: SLICEW];
  assign w_chain[0] = r_carry;

  generate
    for (genvar i = 0; i < NCLA; i++) begin : g_cla
      cla_multicycle_add_ctrl_cla4 u_cla4 (
        .a  (w_sa[4*i +: 4]),
        .b  (w_sb[4*i +: 4]),
        .ci (w_chain[i]),
        .s  (w_ss[4*i +: 4]),
        .co (w_chain[i+1])
      );
    end
  endgenerate

`ifdef CLA_ADD_OVF_FLAG_EN
  logic r_ovf;
  logic w_c_into_msb;
  // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ c.
  assign w_c_into_msb = w_sa[SLICEW-1] ^ w_sb[SLICEW-1] ^ w_ss[SLICEW-1];
  assign ovf          = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
`ifdef CLA_ADD_OVF_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_valid) begin
            // Subtract is A + ~B + 1, the +1 folded into the initial carry.
            r_a     <= a;
            r_b     <= b ^ {OPW{sub}};
            r_carry <= cin ^ sub;
            r_idx   <= '0;
            r_state <= S_RUN;
`ifdef CLA_ADD_OVF_FLAG_EN
            r_ovf   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_sum[r_idx*SLICEW +: SLICEW] <= w_ss;
            r_carry <= w_chain[NCLA];
            r_idx   <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
              r_cout  <= w_chain[NCLA];
              r_state <= S_DONE;
`ifdef CLA_ADD_OVF_FLAG_EN
              r_ovf   <= w_c_into_msb ^ w_chain[NCLA];
`endif
            end
          end
        end
        S_DONE: begin
          if (res_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign busy        = (r_state != S_IDLE);
  assign sum         = r_sum;
  assign cout        = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_cla_multicycle_add_ctrl.sv
`default_nettype none
// Testbench for cla_multicycle_add_ctrl: random and directed operations checked
// against an arithmetic reference model.
module tb_cla_multicycle_add_ctrl;
  localparam int OPW    = 64;
  localparam int SLICEW = 16;
  localparam int NSLICE = OPW / SLICEW;
  localparam int BOUND  = 4 * NSLICE + 8;

  logic           clk;
  logic           rst_n;
  logic           start_valid;
  logic           start_ready;
  logic [OPW-1:0] op_a;
  logic [OPW-1:0] op_b;
  logic           op_sub;
  logic           op_cin;
  logic           abort;
  logic           res_valid;
  logic           res_ready;
  logic [OPW-1:0] sum;
  logic           cout;
  logic           busy;
`ifdef CLA_ADD_OVF_FLAG_EN
  logic           ovf;
`endif

  int n_checks;
  int n_fail;

  cla_multicycle_add_ctrl #(.OPW(OPW), .SLICEW(SLICEW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (op_a),
    .b           (op_b),
    .sub         (op_sub),
    .cin         (op_cin),
    .abort       (abort),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout),
`ifdef CLA_ADD_OVF_FLAG_EN
    .ovf         (ovf),
`endif
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: add is a+b+cin; subtract is a-b-cin with cout = "no borrow".
  function automatic void model(input logic [OPW-1:0] ma, input logic [OPW-1:0] mb,
                                input logic ms, input logic mc,
                                output logic [OPW-1:0] es, output logic ec, output logic ev);
    logic [OPW:0]          u;
    logic signed [OPW+1:0] sa, sb, sx;
    sa = {{2{ma[OPW-1]}}, ma};
    sb = {{2{mb[OPW-1]}}, mb};
    if (ms) begin
      u  = {1'b1, ma} - {1'b0, mb} - {{OPW{1'b0}}, mc};
      sx = sa - sb - {{(OPW+1){1'b0}}, mc};
    end else begin
      u  = {1'b0, ma} + {1'b0, mb} + {{OPW{1'b0}}, mc};
      sx = sa + sb + {{(OPW+1){1'b0}}, mc};
    end
    es = u[OPW-1:0];
    ec = u[OPW];
    ev = (sx[OPW+1:OPW-1] != 3'b000) && (sx[OPW+1:OPW-1] != 3'b111);
  endfunction

  function automatic logic [OPW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one request from IDLE; lat = cycles from acceptance edge to res_valid (0 on timeout).
  task automatic run_op(input logic [OPW-1:0] ta, input logic [OPW-1:0] tb2,
                        input logic ts, input logic tc, output int lat);
    op_a = ta; op_b = tb2; op_sub = ts; op_cin = tc;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    op_a = rnd64(); op_b = rnd64(); op_sub = 1'($urandom); op_cin = 1'($urandom);
    lat = 0;
    for (int i = 1; i <= BOUND; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_valid = 1'b0; abort = 1'b0; res_ready = 1'b0;
    op_a = '0; op_b = '0; op_sub = 1'b0; op_cin = 1'b0;
    #12;
    n_checks++;
    if ({res_valid, busy, start_ready, cout} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/ready/cout=%b want 0010", {res_valid, busy, start_ready, cout});
    end
    n_checks++;
    if (sum !== '0) begin
      n_fail++;
      $display("FAIL reset_sum: got %h want 0", sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [OPW-1:0] ta [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'h0000_0000_0000_FFFF,
                               64'h0000_FFFF_FFFF_FFFF, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF,
                               64'h8000_0000_0000_0000};
    logic [OPW-1:0] tbv [7] = '{64'd1, 64'd7, 64'd1, 64'd1, 64'd0, 64'd1, 64'd1};
    logic           tsv [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic           tcv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [OPW-1:0] es;
    logic           ec, ev;
    int             lat;
    for (int k = 0; k < 7; k++) begin
      model(ta[k], tbv[k], tsv[k], tcv[k], es, ec, ev);
      run_op(ta[k], tbv[k], tsv[k], tcv[k], lat);
      n_checks++;
      if (lat != NSLICE) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", k, lat, NSLICE);
      end
      n_checks++;
      if (sum !== es || cout !== ec) begin
        n_fail++;
        $display("FAIL directed_result[%0d]: got sum=%h cout=%b want sum=%h cout=%b", k, sum, cout, es, ec);
      end
`ifdef CLA_ADD_OVF_FLAG_EN
      n_checks++;
      if (ovf !== ev) begin
        n_fail++;
        $display("FAIL directed_ovf[%0d]: got %b want %b", k, ovf, ev);
      end
`endif
      release_res();
      n_checks++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_release[%0d]: got valid=%b ready=%b want 0 1", k, res_valid, start_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [OPW-1:0] ra, rb, es;
    logic           rs, rc, ec, ev;
    int             lat;
    for (int k = 0; k < 24; k++) begin
      ra = rnd64(); rb = rnd64(); rs = 1'($urandom); rc = 1'($urandom);
      if (k % 6 == 0) rb = ~ra;
      model(ra, rb, rs, rc, es, ec, ev);
      run_op(ra, rb, rs, rc, lat);
      n_checks++;
      if (lat != NSLICE || sum !== es || cout !== ec) begin
        n_fail++;
        $display("FAIL random[%0d]: got lat=%0d sum=%h cout=%b want lat=%0d sum=%h cout=%b",
                 k, lat, sum, cout, NSLICE, es, ec);
      end
`ifdef CLA_ADD_OVF_FLAG_EN
      n_checks++;
      if (ovf !== ev) begin
        n_fail++;
        $display("FAIL random_ovf[%0d]: got %b want %b", k, ovf, ev);
      end
`endif
      release_res();
    end
  endtask

  task automatic test_backpressure();
    logic [OPW-1:0] ra, rb, es;
    logic           ec, ev;
    int             lat;
    int             bad;
    ra = rnd64(); rb = rnd64();
    model(ra, rb, 1'b0, 1'b1, es, ec, ev);
    run_op(ra, rb, 1'b0, 1'b1, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      op_a = rnd64(); op_b = rnd64(); start_valid = ~start_valid;
      abort = (i == 4);
      @(posedge clk); #1;
      if (sum !== es || cout !== ec || start_ready !== 1'b0 || res_valid !== 1'b1) bad++;
    end
    start_valid = 1'b0; abort = 1'b0;
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0 (sum=%h want %h)", bad, sum, es);
    end
    release_res();
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got valid=%b busy=%b ready=%b want 0 0 1", res_valid, busy, start_ready);
    end
  endtask

  task automatic test_abort();
    logic [OPW-1:0] ra, rb, es;
    logic           ec, ev;
    int             lat;
    int             seen;
    op_a = rnd64(); op_b = rnd64(); op_sub = 1'b0; op_cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got busy=%b ready=%b valid=%b want 0 1 0", busy, start_ready, res_valid);
    end
    seen = 0;
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    ra = rnd64(); rb = rnd64();
    model(ra, rb, 1'b1, 1'b1, es, ec, ev);
    run_op(ra, rb, 1'b1, 1'b1, lat);
    n_checks++;
    if (lat != NSLICE || sum !== es || cout !== ec) begin
      n_fail++;
      $display("FAIL abort_next_op: got lat=%0d sum=%h cout=%b want %0d %h %b", lat, sum, cout, NSLICE, es, ec);
    end
    release_res();
  endtask

  task automatic test_reset_during_run();
    int seen;
    op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h1111_2222_3333_4444; op_sub = 1'b0; op_cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || sum !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got valid=%b busy=%b sum=%h want 0 0 0", res_valid, busy, sum);
    end
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (start_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_run_ready: got %b want 1", start_ready);
    end
    seen = 0;
    for (int i = 0; i < NSLICE + 2; i++) begin
      @(posedge clk); #1;
      if (res_valid || busy) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_run_quiet: got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [OPW-1:0] a1, b1, a2, b2, e1, e2;
    logic           c1, c2, v1, v2;
    int             lat;
    a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
    model(a1, b1, 1'b0, 1'b0, e1, c1, v1);
    model(a2, b2, 1'b1, 1'b0, e2, c2, v2);
    res_ready = 1'b1;
    op_a = a1; op_b = b1; op_sub = 1'b0; op_cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk); #1;
    op_a = a2; op_b = b2; op_sub = 1'b1;
    lat = 0;
    for (int i = 1; i <= BOUND; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = i; break; end
    end
    n_checks++;
    if (lat != NSLICE || sum !== e1 || cout !== c1) begin
      n_fail++;
      $display("FAIL b2b_first: got lat=%0d sum=%h cout=%b want %0d %h %b", lat, sum, cout, NSLICE, e1, c1);
    end
    @(posedge clk); #1;
    n_checks++;
    if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got ready=%b valid=%b want 1 0", start_ready, res_valid);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= BOUND; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin lat = i; break; end
    end
    n_checks++;
    if (lat != NSLICE || sum !== e2 || cout !== c2) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d sum=%h cout=%b want %0d %h %b", lat, sum, cout, NSLICE, e2, c2);
    end
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_reset_during_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_multicycle_add_ctrl.md
Name: cla_multicycle_add_ctrl

Overview:
Sequencer that performs a wide (OPW-bit) add or subtract over multiple cycles by reusing one SLICEW-bit carry-lookahead slice adder, processing one slice per cycle from LSB to MSB.
- The slice adder is built from the team's 4-bit lookahead carry units and is instantiated inside this block.
- Carry is registered between slices.
- Sits between the ALU issue logic and wide-operand consumers, with valid/ready handshakes on both sides.

Parameters:
OPW, 64, total operand/result width; must be a multiple of SLICEW.
SLICEW, 16, slice adder width; must be a multiple of 4.
NSLICE, OPW/SLICEW, derived slice count; must be >= 2. Any violation is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  request valid
start_ready  output  1  block can accept a request
a  input  OPW  operand A
b  input  OPW  operand B
sub  input  1  1 = A - B, 0 = A + B
cin  input  1  carry-in
abort  input  1  synchronous cancel of an operation in progress
res_valid  output  1  result valid
res_ready  input  1  consumer accepts result
sum  output  OPW  result
cout  output  1  carry out of bit OPW-1 (raw carry; for subtract, 1 = no borrow)
busy  output  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; operand, result, carry and slice-index registers cleared to 0.
  - res_valid = 0, sum = 0, cout = 0, busy = 0, start_ready = 1.
  - Reset asserted mid-operation discards the operation. No result is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready = 1.
  - On start_valid & start_ready: latch a, latch (b XOR {OPW{sub}}), carry = cin XOR sub, idx = 0; go to RUN.
- RUN:
  - start_ready = 0.
  - Each cycle: slice idx result = a_slice + b_slice + carry, written to sum[idx*SLICEW +: SLICEW]; carry <= slice carry-out; idx <= idx + 1.
  - When idx == NSLICE-1, that slice is written, cout <= its carry-out, and state goes to DONE.
- DONE:
  - res_valid = 1; sum and cout are held stable.
  - On res_ready, go to IDLE; res_valid deasserts the next cycle.
  - start_ready = 0, so back-to-back requests are separated by at least one IDLE cycle.
- Latency: the acceptance edge is E0. res_valid is high after edge E_NSLICE (4 cycles at defaults). Throughput is one operation per NSLICE+2 cycles with res_ready held at 1.
- Inputs a, b, sub and cin are ignored outside the acceptance cycle. Changing them during RUN or DONE has no effect.
- abort:
  - In RUN: go to IDLE next edge; res_valid never asserts; sum contents are undefined-but-stable (not required to be cleared).
  - In IDLE or DONE: ignored. A completed result is always delivered.
- abort and res_ready in the same DONE cycle: normal completion.
- start_valid while not ready: ignored. The requester must hold it until accepted.
- Wrap-around: result is modulo 2^OPW. The carry out of the MSB appears only on cout.
- sum is registered and changes only during RUN; it is never driven combinationally from the inputs.

Optional Feature:
CLA_ADD_OVF_FLAG_EN
- Defined:
  - Adds output port ovf (1 bit) for signed overflow.
  - ovf = (carry into bit OPW-1) XOR (carry out of bit OPW-1), captured on the last RUN slice.
  - Valid and held with res_valid; reset value 0; cleared on acceptance of a new request.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Reset during RUN: assert rst_n low at slice 2 -> immediately res_valid=0, busy=0, sum=0; after release start_ready=1, and no result appears.
2. a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> sum=0, cout=1; res_valid rises exactly 4 cycles after the acceptance edge.
3. Subtract, a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0.
4. Slice carry chain:
   - a=0x0000_0000_0000_FFFF, b=1 -> sum=0x0000_0000_0001_0000, cout=0.
   - a=0x0000_FFFF_FFFF_FFFF, b=1 -> sum=0x0001_0000_0000_0000.
   - a=b=0, cin=1 -> sum=1.
5. Backpressure: hold res_ready=0 for 10 cycles while toggling a, b and start_valid -> sum and cout are stable, start_ready=0, and no second request is accepted. Raising res_ready returns the block to IDLE the next cycle.
6. abort asserted during the second RUN cycle -> IDLE next cycle, res_valid stays 0, and a new request is accepted normally. With CLA_ADD_OVF_FLAG_EN: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> ovf=1, cout=0.
